parking_lot_tracker: RTL and testbench

Parametrised parking-lot meter core for NUM_SPOTS spaces over a NUM_HOURS business day. It detects per-spot arrivals, keeps a saturating cumulative arrival count, logs that count into a per-hour register file on each hour advance, and tracks the rush-hour window (hours with the lot full). At end of day it enters a playback mode that steps through the hourly log for display. It sits between the sensor and KEY single-press conditioning and the HEX and LED display logic in the top level.

---
 rtl/parking_lot_tracker_pkg.sv | 32 +++
 rtl/parking_lot_tracker_if.sv | 56 +++++
 rtl/parking_lot_tracker_arrival_detector.sv | 57 +++++
 rtl/parking_lot_tracker.sv | 178 +++++++++++++++++
 tb/tb_parking_lot_tracker.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/parking_lot_tracker_pkg.sv
// Shared types and helpers for the parking-lot meter core.
//
// Contents:
//   park_state_e : day-counting vs. end-of-day playback state
//   DEF_*        : default parameter values for the core
//   MAX_SPOTS    : widest presence vector the helpers accept
//   popcount()   : number of set bits in a presence/edge vector
//
// Optional feature macro used elsewhere in the slice: PARK_PEAK_OCC_EN.
package parking_pkg;

  typedef enum logic {
    PK_DAY      = 1'b0,
    PK_PLAYBACK = 1'b1
  } park_state_e;

  localparam int DEF_NUM_SPOTS = 3;
  localparam int DEF_NUM_HOURS = 8;
  localparam int DEF_CNT_W     = 5;
  localparam int MAX_SPOTS     = 15;

  // Callers zero-extend their vector to MAX_SPOTS bits; result fits 0..15.
  function automatic logic [3:0] popcount(input logic [MAX_SPOTS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_SPOTS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/parking_lot_tracker_if.sv
// Bundle of sensor/control inputs and meter outputs for parking_lot_tracker.
//
// Signals:
//   presence[NUM_SPOTS] : per-spot car sensors (synchronised, 1 = present)
//   hour_adv, scroll_tick : single-cycle command pulses
//   occupied, full, hour, day_done, arrivals_total : live meter status
//   rd_hour, rd_data, peak_occ : hourly log playback port (1-cycle latency)
//   rush_valid, rush_start, rush_end : rush-hour window
//   state_dbg : current FSM state for observation
//
// Handshake: there is no ready/backpressure. hour_adv and scroll_tick act as
// valid strobes that are always accepted on the cycle they are high (subject
// to the FSM state ignoring them); holding one high for N cycles means N
// commands. Status outputs are valid every cycle.
//
// Modports: master drives the inputs (board glue / testbench), slave is the core.
interface parking_lot_tracker_if #(
  parameter int NUM_SPOTS = 3,
  parameter int NUM_HOURS = 8,
  parameter int CNT_W     = 5
) ();
  import parking_pkg::*;

  localparam int HR_W  = $clog2(NUM_HOURS + 1);
  localparam int OCC_W = $clog2(NUM_SPOTS + 1);

  logic [NUM_SPOTS-1:0] presence;
  logic                 hour_adv;
  logic                 scroll_tick;

  logic [OCC_W-1:0]     occupied;
  logic                 full;
  logic [HR_W-1:0]      hour;
  logic                 day_done;
  logic [CNT_W-1:0]     arrivals_total;
  logic [HR_W-1:0]      rd_hour;
  logic [CNT_W-1:0]     rd_data;
  logic                 rush_valid;
  logic [HR_W-1:0]      rush_start;
  logic [HR_W-1:0]      rush_end;
  logic [OCC_W-1:0]     peak_occ;
  park_state_e          state_dbg;

  modport master (
    output presence, hour_adv, scroll_tick,
    input  occupied, full, hour, day_done, arrivals_total, rd_hour, rd_data,
           rush_valid, rush_start, rush_end, peak_occ, state_dbg
  );

  modport slave (
    input  presence, hour_adv, scroll_tick,
    output occupied, full, hour, day_done, arrivals_total, rd_hour, rd_data,
           rush_valid, rush_start, rush_end, peak_occ, state_dbg
  );

endinterface

// File: rtl/parking_lot_tracker_arrival_detector.sv
// Per-spot arrival detector with a saturating cumulative arrival counter.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   freeze         : hold arrivals_total (playback); prev_presence keeps tracking
//   presence       : per-spot sensors
//   edges          : rising edges of presence this cycle
//   arrivals_total : registered cumulative arrivals, saturating at 2^CNT_W-1
//   arrivals_next  : value arrivals_total takes at the next edge, so a log
//                    write on this cycle includes this cycle's arrivals
module arrival_detector
  import parking_pkg::*;
#(
  parameter int NUM_SPOTS = DEF_NUM_SPOTS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic [NUM_SPOTS-1:0] presence,
  output logic [NUM_SPOTS-1:0] edges,
  output logic [CNT_W-1:0]     arrivals_total,
  output logic [CNT_W-1:0]     arrivals_next
);

  // Headroom so total + up to 15 new arrivals never wraps before the clamp.
  localparam int SUM_W = CNT_W + 5;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [NUM_SPOTS-1:0] prev_q, prev_d;
  logic [CNT_W-1:0]     total_q, total_d;
  logic [SUM_W-1:0]     sum;

  always_comb begin
    edges   = presence & ~prev_q;
    sum     = SUM_W'(total_q) + SUM_W'(popcount(MAX_SPOTS'(edges)));
    prev_d  = presence;
    total_d = total_q;
    if (!freeze) begin
      total_d = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      total_q <= '0;
    end else begin
      prev_q  <= prev_d;
      total_q <= total_d;
    end
  end

  assign arrivals_total = total_q;
  assign arrivals_next  = total_d;

endmodule

// File: rtl/parking_lot_tracker.sv
// Parking-lot meter core: live occupancy, saturating arrival count, per-hour
// arrival log, rush-hour window (hours in which the lot was full), and an
// end-of-day playback mode that scrolls through the log.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : parking_lot_tracker_if.slave (sensors, pulses, all status)
//
// Build option: define PARK_PEAK_OCC_EN to also log the peak occupancy of
// each hour and present it on peak_occ alongside rd_data; otherwise peak_occ
// is tied to 0.
module parking_lot_tracker
  import parking_pkg::*;
#(
  parameter int NUM_SPOTS = DEF_NUM_SPOTS,
  parameter int NUM_HOURS = DEF_NUM_HOURS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  parking_lot_tracker_if.slave bus
);

  localparam int HR_W      = $clog2(NUM_HOURS + 1);
  localparam int OCC_W     = $clog2(NUM_SPOTS + 1);
  // Full power-of-two depth so rd_hour indexes without a width mismatch;
  // entries at NUM_HOURS and above are never written and stay 0.
  localparam int LOG_DEPTH = 1 << HR_W;
  localparam logic [HR_W-1:0] LAST_HOUR = HR_W'(NUM_HOURS - 1);
  localparam logic [HR_W-1:0] END_HOUR  = HR_W'(NUM_HOURS);

  logic [OCC_W-1:0]     occupied;
  logic                 full;
  logic                 in_day;
  logic                 adv;
  logic [NUM_SPOTS-1:0] arr_edges_unused;
  logic [CNT_W-1:0]     arr_total;
  logic [CNT_W-1:0]     arr_next;

  park_state_e      state_q, state_d;
  logic [HR_W-1:0]  hour_q, hour_d;
  logic [HR_W-1:0]  rd_hour_q, rd_hour_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rush_valid_q, rush_valid_d;
  logic [HR_W-1:0]  rush_start_q, rush_start_d;
  logic [HR_W-1:0]  rush_end_q, rush_end_d;
  logic             full_seen_q, full_seen_d;
  logic [CNT_W-1:0] log_q [LOG_DEPTH];

  assign occupied = OCC_W'(popcount(MAX_SPOTS'(bus.presence)));
  assign full     = (occupied == OCC_W'(NUM_SPOTS));
  assign in_day   = (state_q == PK_DAY);
  assign adv      = in_day && bus.hour_adv;

  arrival_detector #(
    .NUM_SPOTS (NUM_SPOTS),
    .CNT_W     (CNT_W)
  ) u_arrivals (
    .clk            (clk),
    .rst            (rst),
    .freeze         (!in_day),
    .presence       (bus.presence),
    .edges          (arr_edges_unused),
    .arrivals_total (arr_total),
    .arrivals_next  (arr_next)
  );

  always_comb begin
    state_d      = state_q;
    hour_d       = hour_q;
    rd_hour_d    = rd_hour_q;
    rush_valid_d = rush_valid_q;
    rush_start_d = rush_start_q;
    rush_end_d   = rush_end_q;
    full_seen_d  = full_seen_q;
    rd_data_d    = (rd_hour_q < END_HOUR) ? log_q[rd_hour_q] : '0;

    case (state_q)
      PK_DAY: begin
        if (full) full_seen_d = 1'b1;
        rd_hour_d = hour_q;
        if (bus.hour_adv) begin
          // Hour counts as rush if the lot was full at any point in it,
          // including this closing cycle.
          if (full_seen_q || full) begin
            rush_end_d = hour_q;
            if (!rush_valid_q) begin
              rush_start_d = hour_q;
              rush_valid_d = 1'b1;
            end
          end
          full_seen_d = 1'b0;
          hour_d      = hour_q + 1'b1;
          rd_hour_d   = hour_q + 1'b1;
          if (hour_q == LAST_HOUR) begin
            state_d   = PK_PLAYBACK;
            rd_hour_d = '0;
          end
        end
      end
      PK_PLAYBACK: begin
        if (bus.scroll_tick) begin
          rd_hour_d = (rd_hour_q == LAST_HOUR) ? '0 : rd_hour_q + 1'b1;
        end
      end
      default: state_d = PK_DAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PK_DAY;
      hour_q       <= '0;
      rd_hour_q    <= '0;
      rd_data_q    <= '0;
      rush_valid_q <= 1'b0;
      rush_start_q <= '1;
      rush_end_q   <= '1;
      full_seen_q  <= 1'b0;
      for (int i = 0; i < LOG_DEPTH; i++) log_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      rd_hour_q    <= rd_hour_d;
      rd_data_q    <= rd_data_d;
      rush_valid_q <= rush_valid_d;
      rush_start_q <= rush_start_d;
      rush_end_q   <= rush_end_d;
      full_seen_q  <= full_seen_d;
      if (adv) log_q[hour_q] <= arr_next;
    end
  end

`ifdef PARK_PEAK_OCC_EN
  logic [OCC_W-1:0] peak_run_q, peak_run_d;
  logic [OCC_W-1:0] peak_occ_q, peak_occ_d;
  logic [OCC_W-1:0] peak_max;
  logic [OCC_W-1:0] peak_log_q [LOG_DEPTH];

  assign peak_max = (occupied > peak_run_q) ? occupied : peak_run_q;

  always_comb begin
    peak_run_d = peak_run_q;
    // Running max restarts from the live occupancy at each hour boundary.
    if (in_day) peak_run_d = adv ? occupied : peak_max;
    peak_occ_d = (rd_hour_q < END_HOUR) ? peak_log_q[rd_hour_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_run_q <= '0;
      peak_occ_q <= '0;
      for (int i = 0; i < LOG_DEPTH; i++) peak_log_q[i] <= '0;
    end else begin
      peak_run_q <= peak_run_d;
      peak_occ_q <= peak_occ_d;
      if (adv) peak_log_q[hour_q] <= peak_max;
    end
  end

  assign bus.peak_occ = peak_occ_q;
`else
  assign bus.peak_occ = '0;
`endif

  assign bus.occupied       = occupied;
  assign bus.full           = full;
  assign bus.hour           = hour_q;
  assign bus.day_done       = (state_q == PK_PLAYBACK);
  assign bus.arrivals_total = arr_total;
  assign bus.rd_hour        = rd_hour_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rush_valid     = rush_valid_q;
  assign bus.rush_start     = rush_start_q;
  assign bus.rush_end       = rush_end_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_parking_lot_tracker.sv
// Self-checking bench for parking_lot_tracker (NUM_SPOTS=3, NUM_HOURS=8, CNT_W=5).
// Every cycle is compared against a behavioural model of the meter rules;
// directed table/sequences add constant expectations for the corner cases.
module tb_parking_lot_tracker;

  localparam int NS = 3;
  localparam int NH = 8;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  parking_lot_tracker_if #(.NUM_SPOTS(NS), .NUM_HOURS(NH), .CNT_W(CW)) bus ();

  parking_lot_tracker #(.NUM_SPOTS(NS), .NUM_HOURS(NH), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // ---------------- scoreboard ----------------
  logic [CW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int       m_log[NH];
  int       m_peak_log[NH];
  int       m_total, m_hour, m_rd, m_rd_data, m_rs, m_re, m_peak_run, m_peak_occ;
  bit       m_rv, m_fs, m_play;
  logic [NS-1:0] m_prev;
  logic [NS-1:0] m_pres;

  task automatic model_step(input logic [NS-1:0] pres, input logic adv,
                            input logic scroll, input logic r);
    int occ;
    int new_rd, new_pk;
    occ    = $countones(pres);
    m_pres = pres;
    if (r) begin
      foreach (m_log[i]) begin m_log[i] = 0; m_peak_log[i] = 0; end
      m_total = 0; m_hour = 0; m_rd = 0; m_rd_data = 0; m_rs = 15; m_re = 15;
      m_rv = 0; m_fs = 0; m_play = 0; m_prev = '0; m_peak_run = 0; m_peak_occ = 0;
    end else begin
      new_rd = (m_rd < NH) ? m_log[m_rd] : 0;
      new_pk = (m_rd < NH) ? m_peak_log[m_rd] : 0;
      if (!m_play) begin
        int nt;
        bit full_now;
        full_now = (occ == NS);
        nt = m_total + $countones(pres & ~m_prev);
        if (nt > 31) nt = 31;
        if (adv) begin
          m_log[m_hour]      = nt;
          m_peak_log[m_hour] = (occ > m_peak_run) ? occ : m_peak_run;
          m_peak_run         = occ;
          if (m_fs || full_now) begin
            m_re = m_hour;
            if (!m_rv) begin m_rs = m_hour; m_rv = 1; end
          end
          m_fs   = 0;
          m_hour = m_hour + 1;
          if (m_hour == NH) begin m_play = 1; m_rd = 0; end
          else m_rd = m_hour;
        end else begin
          if (full_now) m_fs = 1;
          if (occ > m_peak_run) m_peak_run = occ;
          m_rd = m_hour;
        end
        m_total = nt;
      end else if (scroll) begin
        m_rd = (m_rd + 1) % NH;
      end
      m_prev     = pres;
      m_rd_data  = new_rd;
      m_peak_occ = new_pk;
    end
    exp_q.push_back(CW'(m_rd_data));
  endtask

  task automatic check_all();
    logic [CW-1:0] e;
    chk("occupied", bus.occupied, $countones(m_pres));
    chk("full", bus.full, ($countones(m_pres) == NS));
    chk("hour", bus.hour, m_hour);
    chk("day_done", bus.day_done, m_play);
    chk("arrivals_total", bus.arrivals_total, m_total);
    chk("rd_hour", bus.rd_hour, m_rd);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("rd_data", bus.rd_data, e);
    chk("rush_valid", bus.rush_valid, m_rv);
    chk("rush_start", bus.rush_start, m_rs);
    chk("rush_end", bus.rush_end, m_re);
`ifdef PARK_PEAK_OCC_EN
    chk("peak_occ", bus.peak_occ, m_peak_occ);
`else
    chk("peak_occ", bus.peak_occ, 0);
`endif
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [NS-1:0] pres, input logic adv,
                       input logic scroll, input logic r);
    bus.presence    = pres;
    bus.hour_adv    = adv;
    bus.scroll_tick = scroll;
    rst             = r;
    model_step(pres, adv, scroll, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [NS-1:0] pres;
    logic          adv;
    int            e_hour;
    int            e_total;
    logic          e_full;
  } vec_t;

  vec_t day_tbl[13];
  int   exp_log[NH];

  initial begin
    logic [NS-1:0] rp;

    // Full-day schedule: arrivals during hours 1/3/5, departures coincide with
    // the pulse that closes hour 6, so hours 5 and 6 are the only full hours.
    day_tbl[0]  = '{3'b000, 1'b1, 1, 0, 1'b0};
    day_tbl[1]  = '{3'b001, 1'b0, 1, 1, 1'b0};
    day_tbl[2]  = '{3'b001, 1'b1, 2, 1, 1'b0};
    day_tbl[3]  = '{3'b001, 1'b1, 3, 1, 1'b0};
    day_tbl[4]  = '{3'b011, 1'b0, 3, 2, 1'b0};
    day_tbl[5]  = '{3'b011, 1'b1, 4, 2, 1'b0};
    day_tbl[6]  = '{3'b011, 1'b1, 5, 2, 1'b0};
    day_tbl[7]  = '{3'b111, 1'b0, 5, 3, 1'b1};
    day_tbl[8]  = '{3'b111, 1'b1, 6, 3, 1'b1};
    day_tbl[9]  = '{3'b111, 1'b0, 6, 3, 1'b1};
    day_tbl[10] = '{3'b000, 1'b1, 7, 3, 1'b0};
    day_tbl[11] = '{3'b000, 1'b0, 7, 3, 1'b0};
    day_tbl[12] = '{3'b000, 1'b1, 8, 3, 1'b0};
    exp_log = '{0, 1, 1, 2, 2, 3, 3, 3};

    // Reset state
    do_reset();
    chk("rst hour", bus.hour, 0);
    chk("rst arrivals", bus.arrivals_total, 0);
    chk("rst rush_valid", bus.rush_valid, 0);
    chk("rst rush_start", bus.rush_start, 4'hF);
    chk("rst rush_end", bus.rush_end, 4'hF);
    chk("rst day_done", bus.day_done, 0);
    chk("rst rd_data", bus.rd_data, 0);

    // Full day from the table
    for (int i = 0; i < 13; i++) begin
      cycle(day_tbl[i].pres, day_tbl[i].adv, 1'b0, 1'b0);
      chk("tbl hour", bus.hour, day_tbl[i].e_hour);
      chk("tbl arrivals", bus.arrivals_total, day_tbl[i].e_total);
      chk("tbl full", bus.full, day_tbl[i].e_full);
    end
    chk("day day_done", bus.day_done, 1);
    chk("day rush_valid", bus.rush_valid, 1);
    chk("day rush_start", bus.rush_start, 5);
    chk("day rush_end", bus.rush_end, 6);

    // Playback scroll with wrap; hour_adv must be ignored
    cycle('0, 1'b0, 1'b0, 1'b0);
    chk("pb rd_data0", bus.rd_data, exp_log[0]);
    for (int k = 1; k <= 9; k++) begin
      cycle('0, 1'b0, 1'b1, 1'b0);
      chk("pb rd_hour", bus.rd_hour, k % NH);
      cycle('0, 1'b1, 1'b0, 1'b0);
      chk("pb rd_data", bus.rd_data, exp_log[k % NH]);
      chk("pb hour held", bus.hour, NH);
    end

    // Reset during playback clears the log
    do_reset();
    chk("rpb hour", bus.hour, 0);
    chk("rpb rush_valid", bus.rush_valid, 0);
    chk("rpb day_done", bus.day_done, 0);
    for (int h = 0; h < NH; h++) cycle('0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NH; k++) begin
      cycle('0, 1'b0, 1'b0, 1'b0);
      chk("rpb log zero", bus.rd_data, 0);
      cycle('0, 1'b0, 1'b1, 1'b0);
    end

    // Coincident arrivals and hour advance in hour 0
    do_reset();
    cycle(3'b111, 1'b1, 1'b0, 1'b0);
    chk("coin arrivals", bus.arrivals_total, 3);
    chk("coin rush_start", bus.rush_start, 0);
    chk("coin rush_end", bus.rush_end, 0);
    chk("coin rush_valid", bus.rush_valid, 1);
    for (int h = 1; h < NH; h++) cycle(3'b111, 1'b1, 1'b0, 1'b0);
    cycle(3'b111, 1'b0, 1'b0, 1'b0);
    chk("coin log0", bus.rd_data, 3);

    // Saturation: 40 arrivals on spot 0
    do_reset();
    for (int k = 0; k < 40; k++) begin
      cycle(3'b001, 1'b0, 1'b0, 1'b0);
      cycle(3'b000, 1'b0, 1'b0, 1'b0);
    end
    chk("sat arrivals", bus.arrivals_total, 31);

    // Randomised traffic against the model
    do_reset();
    rp = '0;
    for (int n = 0; n < 600; n++) begin
      rp = rp ^ (NS'($urandom_range(0, 7)) & NS'($urandom_range(0, 7)));
      cycle(rp, ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
